// File: rtl/makestuff_reg_arbiter_if.sv
// Register channel bundle between two upstream masters, the arbiter and the
// application register file. The "master" modport is the arbiter's view (it
// drives the register file and answers the masters); "slave" is the view of
// the surrounding logic that drives requests and models the register file.
interface makestuff_reg_arbiter_if #(
    parameter int CHAN_W = 7,
    parameter int DATA_W = 32
);
    // Upstream masters, index m = 0 (TLP CPU port) or 1 (local master)
    logic [1:0][CHAN_W-1:0] mChan_in;
    logic [1:0][DATA_W-1:0] mWrData_in;
    logic [1:0]             mWrValid_in;
    logic [1:0]             mWrReady_out;
    logic [1:0][DATA_W-1:0] mRdData_out;
    logic [1:0]             mRdValid_out;
    logic [1:0]             mRdReady_in;

    // Downstream register file
    logic [CHAN_W-1:0]      sChan_out;
    logic [DATA_W-1:0]      sWrData_out;
    logic                   sWrValid_out;
    logic                   sWrReady_in;
    logic [DATA_W-1:0]      sRdData_in;
    logic                   sRdValid_in;
    logic                   sRdReady_out;

    modport master (
        input  mChan_in, mWrData_in, mWrValid_in, mRdReady_in,
               sWrReady_in, sRdData_in, sRdValid_in,
        output mWrReady_out, mRdData_out, mRdValid_out,
               sChan_out, sWrData_out, sWrValid_out, sRdReady_out
    );

    modport slave (
        output mChan_in, mWrData_in, mWrValid_in, mRdReady_in,
               sWrReady_in, sRdData_in, sRdValid_in,
        input  mWrReady_out, mRdData_out, mRdValid_out,
               sChan_out, sWrData_out, sWrValid_out, sRdReady_out
    );
endinterface

// File: rtl/makestuff_reg_arbiter.sv
// Two-master round-robin arbiter for the register read/write channel.
// One transaction per grant; a watchdog forces completion of transactions
// the register file never finishes so the PCIe completion path cannot hang.
module makestuff_reg_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
    parameter int          CHAN_W   = 7,
    parameter int          DATA_W   = 32
) (
    input  logic                        pcieClk_in,
    input  logic                        reset_in,
    makestuff_reg_arbiter_if.master     bus,
    output logic [15:0]                 errCount_out,
    output logic                        busy_out
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic { S_IDLE, S_BUSY } state_t;

    state_t            state_q, state_d;
    logic              gnt_q,   gnt_d;    // granted master
    logic              opWr_q,  opWr_d;   // 1 = write transaction, 0 = read
    logic              last_q,  last_d;   // last master served; reset to 1 so M0 wins first tie
    logic [WD_W-1:0]   wdog_q,  wdog_d;
    logic [15:0]       errCnt_q, errCnt_d;

    logic [1:0]        req;
    logic              reqG;      // granted master still requesting its latched op
    logic              timeout;   // forced-completion cycle
    logic              done;      // genuine slave handshake this cycle

    assign req = bus.mWrValid_in | bus.mRdReady_in;

    // Next-state, pass-through muxing and watchdog-forced responses
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        opWr_d   = opWr_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        errCnt_d = errCnt_q;
        timeout  = 1'b0;
        done     = 1'b0;
        reqG     = opWr_q ? bus.mWrValid_in[gnt_q] : bus.mRdReady_in[gnt_q];

        bus.mWrReady_out = '0;
        bus.mRdData_out  = '0;
        bus.mRdValid_out = '0;
        bus.sChan_out    = '0;
        bus.sWrData_out  = '0;
        bus.sWrValid_out = 1'b0;
        bus.sRdReady_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // Tie goes to whoever was not served last
                    gnt_d   = (&req) ? ~last_q : req[1];
                    // A master asking for both gets its write done first
                    opWr_d  = bus.mWrValid_in[gnt_d];
                    wdog_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                bus.sChan_out   = bus.mChan_in[gnt_q];
                bus.sWrData_out = bus.mWrData_in[gnt_q];
                timeout = reqG && (wdog_q == WD_W'(TIMEOUT));
                if (opWr_q) begin
                    if (timeout) begin
                        // Drop the data, but release the master
                        bus.mWrReady_out[gnt_q] = 1'b1;
                    end else begin
                        bus.sWrValid_out        = bus.mWrValid_in[gnt_q];
                        bus.mWrReady_out[gnt_q] = bus.sWrReady_in;
                        done = bus.mWrValid_in[gnt_q] & bus.sWrReady_in;
                    end
                end else begin
                    if (timeout) begin
                        bus.mRdValid_out[gnt_q] = 1'b1;
                        bus.mRdData_out[gnt_q]  = DATA_W'(ERR_DATA);
                    end else begin
                        bus.sRdReady_out        = bus.mRdReady_in[gnt_q];
                        bus.mRdData_out[gnt_q]  = bus.sRdData_in;
                        bus.mRdValid_out[gnt_q] = bus.sRdValid_in;
                        done = bus.mRdReady_in[gnt_q] & bus.sRdValid_in;
                    end
                end

                if (!reqG) begin
                    // Master withdrew: abandon quietly, fairness pointer untouched
                    state_d = S_IDLE;
                end else if (done || timeout) begin
                    state_d = S_IDLE;
                    last_d  = gnt_q;
                    wdog_d  = '0;
                    if (timeout && (errCnt_q != 16'hFFFF))
                        errCnt_d = errCnt_q + 16'd1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset drops every handshake in the same cycle it is raised
        if (reset_in) begin
            bus.mWrReady_out = '0;
            bus.mRdData_out  = '0;
            bus.mRdValid_out = '0;
            bus.sChan_out    = '0;
            bus.sWrData_out  = '0;
            bus.sWrValid_out = 1'b0;
            bus.sRdReady_out = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            opWr_q   <= 1'b0;
            last_q   <= 1'b1;
            wdog_q   <= '0;
            errCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            opWr_q   <= opWr_d;
            last_q   <= last_d;
            wdog_q   <= wdog_d;
            errCnt_q <= errCnt_d;
        end
    end

    assign errCount_out = errCnt_q;
    assign busy_out     = (state_q == S_BUSY) && !reset_in;
endmodule
